// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants and types for the RV32M multiply/divide unit
// Purpose: funct3 encodings, FSM state type, iteration count and divide special-case values.
// Ports: none.
package muldiv_pkg;

  localparam int MD_XLEN    = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = 6;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [31:0] DIV0_QUOT    = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUOT     = 32'h8000_0000;
  localparam logic [31:0] OVF_REM      = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // funct3[2] separates the divide group from the multiply group
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit
// Purpose: computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over 32 cycles, one bit per cycle.
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   start_i         begin an operation (accepted only when busy_o is low)
//   funct3_i        operation select
//   rs1_val_i       operand A
//   rs2_val_i       operand B
//   rd_in_i         destination index, captured at accept
//   busy_o          high from the cycle after accept through the done cycle
//   done_o          one-cycle pulse when result_o/rd_out_o are valid
//   result_o        operation result
//   rd_out_o        captured destination index
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic [XLEN-1:0] rs2_val_i,
  input  logic [4:0]      rd_in_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_out_o
);

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          rd_q, rd_d;

  // Operand sign pre-processing, only meaningful in the accept cycle
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3_i)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      F3_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    a_neg    = a_signed & rs1_val_i[XLEN-1];
    b_neg    = b_signed & rs2_val_i[XLEN-1];
    a_mag    = a_neg ? (~rs1_val_i + 1'b1) : rs1_val_i;
    b_mag    = b_neg ? (~rs2_val_i + 1'b1) : rs2_val_i;
    div_zero = is_div(funct3_i) && (rs2_val_i == '0);
    div_ovf  = (funct3_i == F3_DIV || funct3_i == F3_REM) &&
               (rs1_val_i == OVF_DIVIDEND) && (rs2_val_i == OVF_DIVISOR);
  end

  // One iteration of the shared datapath.
  // Multiply: acc = {partial product, remaining multiplier bits}; add then shift right.
  // Divide:   acc = {partial remainder, remaining dividend / quotient bits}; shift left,
  //           trial subtract. The shifted remainder needs XLEN+1 bits before the compare.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_rem;
  logic [XLEN-1:0]   div_sub;
  logic              div_ge;
  logic [2*XLEN-1:0] step_acc;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_rem = acc_q[2*XLEN-1:XLEN-1];
    div_ge  = (div_rem >= {1'b0, opb_q});
    // remainder after subtract is below the divisor, so XLEN bits suffice
    div_sub = div_rem[XLEN-1:0] - opb_q;
    if (is_div(op_q)) begin
      step_acc = {(div_ge ? div_sub : div_rem[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    end else begin
      step_acc = {mul_sum, acc_q[XLEN-1:1]};
    end

    prod_fix = neg_q ? (~step_acc + 1'b1) : step_acc;
    quot_fix = neg_q ? (~step_acc[XLEN-1:0] + 1'b1) : step_acc[XLEN-1:0];
    rem_fix  = neg_q ? (~step_acc[2*XLEN-1:XLEN] + 1'b1) : step_acc[2*XLEN-1:XLEN];

    case (op_q)
      F3_MUL:                        final_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               final_res = quot_fix;
      default:                       final_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    rd_d     = rd_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d  = funct3_i;
          rd_d  = rd_in_i;
          cnt_d = '0;
          opb_d = b_mag;
          acc_d = {{XLEN{1'b0}}, a_mag};
          // remainder follows the dividend; everything else follows the sign product
          neg_d = (funct3_i == F3_REM || funct3_i == F3_REMU) ? a_neg : (a_neg ^ b_neg);
          if (div_zero) begin
            result_d = funct3_i[1] ? rs1_val_i : DIV0_QUOT;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = funct3_i[1] ? OVF_REM : OVF_QUOT;
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
          result_d = final_res;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;
  assign rd_out_o = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_cmp  = 0;
  int n_fail = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start),
    .funct3_i (funct3),
    .rs1_val_i(rs1_val),
    .rs2_val_i(rs2_val),
    .rd_in_i  (rd_in),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result),
    .rd_out_o (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic straight from the RV32M definitions
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'd0: begin p = sa * sb;           return p[31:0];  end
      3'd1: begin p = sa * sb;           return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub;           return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f3 >= 3'd4 && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one operation and watch until two cycles after done (bounded)
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit hold_start,
                        output logic [31:0] res, output logic [4:0] rdo,
                        output int lat, output int busy_n, output int done_n);
    @(negedge clk);
    funct3  = f3;
    rs1_val = a;
    rs2_val = b;
    rd_in   = rd;
    start   = 1'b1;
    res     = '0;
    rdo     = '0;
    lat     = 0;
    busy_n  = 0;
    done_n  = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat == 0) begin
          lat   = n;
          res   = result;
          rdo   = rd_out;
          start = 1'b0;
        end
      end
      if (lat != 0 && n >= lat + 2) break;
    end
    start = 1'b0;
  endtask

  vec_t        vecs[$];
  logic [31:0] res;
  logic [4:0]  rdo;
  int          lat, busy_n, done_n;
  logic [2:0]  f3;
  logic [31:0] a, b;
  logic [4:0]  rd;
  bit          saw_done;

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    funct3  = '0;
    rs1_val = '0;
    rs2_val = '0;
    rd_in   = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   {31'b0, busy}, 32'd0);
    check("reset_done",   {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd_out", {27'b0, rd_out}, 32'd0);
    reset = 1'b0;

    vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    vecs.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33});
    vecs.push_back('{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         33});
    vecs.push_back('{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33});
    vecs.push_back('{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{3'd7, 32'd5,          32'd0,         32'd5,         1});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1});
    vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});

    foreach (vecs[i]) begin
      rd = 5'(i + 3);
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, rd, 1'b0, res, rdo, lat, busy_n, done_n);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_rd_out", i), {27'b0, rdo}, {27'b0, rd});
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'(vecs[i].lat));
      check($sformatf("vec%0d_done_count", i), 32'(done_n), 32'd1);
    end

    // start held high through the whole busy window: only one operation runs
    run_op(3'd0, 32'd1000, 32'd3000, 5'd17, 1'b1, res, rdo, lat, busy_n, done_n);
    check("hold_start_result", res, 32'd3000000);
    check("hold_start_done_count", 32'(done_n), 32'd1);
    check("hold_start_busy_cycles", 32'(busy_n), 32'd33);

    // reset in the middle of CALC (counter value 10)
    @(negedge clk);
    funct3  = 3'd1;
    rs1_val = 32'h1234_5678;
    rs2_val = 32'h9ABC_DEF0;
    rd_in   = 5'd21;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("midcalc_busy_before_reset", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midcalc_reset_busy",   {31'b0, busy}, 32'd0);
    check("midcalc_reset_done",   {31'b0, done}, 32'd0);
    check("midcalc_reset_result", result, 32'd0);
    check("midcalc_reset_rd_out", {27'b0, rd_out}, 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("midcalc_no_done", {31'b0, saw_done}, 32'd0);

    // reset wins over start in the same cycle
    funct3  = 3'd0;
    rs1_val = 32'd9;
    rs2_val = 32'd9;
    start   = 1'b1;
    reset   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    check("reset_over_start_busy", {31'b0, busy}, 32'd0);

    // randomized operations against the reference model
    for (int k = 0; k < 150; k++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      rd = 5'($urandom);
      run_op(f3, a, b, rd, 1'b0, res, rdo, lat, busy_n, done_n);
      check($sformatf("rnd%0d_f3_%0d_%08h_%08h_result", k, f3, a, b), res, ref_model(f3, a, b));
      check($sformatf("rnd%0d_rd_out", k), {27'b0, rdo}, {27'b0, rd});
      check($sformatf("rnd%0d_latency", k), 32'(lat), 32'(ref_latency(f3, a, b)));
      check($sformatf("rnd%0d_done_count", k), 32'(done_n), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the CPU execute stage. It takes the two source-register read values from the register file, together with the destination index, and computes the M-extension result over multiple cycles. It then presents the result and destination index for register-file write-back with a one-cycle `done` pulse. The core stalls instruction issue while `busy` is high.

## Interface
- `XLEN`, default 32: operand and result width; only 32 is supported.
- `clk`  in  1  clock.
- `reset`  in  1  reset: synchronous, active-high.
- `start`  in  1  request to begin an operation; accepted only when `busy`=0.
- `funct3`  in  3  operation select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_val`  in  XLEN  operand A, the rs1 read value.
- `rs2_val`  in  XLEN  operand B, the rs2 read value.
- `rd_in`  in  5  destination register index, captured at accept.
- `busy`  out  1  high from the cycle after accept until the `done` cycle, inclusive.
- `done`  out  1  one-cycle pulse; `result` and `rd_out` are valid in this cycle.
- `result`  out  XLEN  operation result; held until the next accept.
- `rd_out`  out  5  captured `rd_in`; held until the next accept.

## Operation
- States and transitions:
  - IDLE: on `start`, capture `funct3`, operands and `rd_in`, then go to CALC. A special divide case goes directly to DONE instead.
  - CALC: 6-bit counter runs 0..31, one step per cycle. At count 31, apply sign correction and go to DONE.
  - DONE: assert `done`, write `result`, return to IDLE.
- `start` while `busy`=1 is ignored; no queueing.
- Multiply: convert operands to magnitudes by signedness, then perform shift-add over a 64-bit accumulator, one multiplier bit per cycle.
  - Signedness: MUL and MULH treat both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU treats both as unsigned.
  - The 64-bit product is negated if the operand signs differ (signed operands only).
  - MUL returns the low 32 bits; MULH, MULHSU and MULHU return the high 32 bits.
- Divide: restoring division on magnitudes, one quotient bit per cycle.
  - DIV and REM are signed; DIVU and REMU are unsigned.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases, detected at accept, skip CALC:
  - Divide by zero: quotient = 0xFFFFFFFF; remainder = rs1_val.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- All arithmetic is modulo 2^64 internally and truncated to XLEN on output.

## Timing
- Accept at cycle t is registered at the clock edge ending t.
- Normal operation: `busy`=1 in cycles t+1..t+33. CALC occupies t+1..t+32. `done`=1 and `result` is valid in t+33. `busy`=0 in t+34, where the next `start` may be accepted.
- Special divide: `busy`=1 and `done`=1 in t+1; `busy`=0 in t+2.
- `done` is never high for two consecutive cycles.
- Reset, at any time including mid-CALC: state goes to IDLE, `busy`=0, `done`=0, `result`=0, `rd_out`=0, counter and accumulators cleared, all from the next cycle. The interrupted operation produces no `done`. Reset has priority over `start` in the same cycle.
- Reset values: `busy` 0, `done` 0, `result` 0, `rd_out` 0.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `muldiv_pkg` holds:
  - `funct3` localparams: MUL..REMU.
  - State enum: IDLE, CALC, DONE.
  - Constants: `XLEN`, the 32-cycle iteration count, and the special-case values.
- Single module, no sub-module. Sign pre-processing, the iterative datapath (shared 64-bit accumulator plus 32-bit operand register) and post-correction are inline.

## Test plan
- MUL: rs1=7, rs2=0xFFFFFFFD (−3), start at t → `done` at t+33, result=0xFFFFFFEB, rd_out equals rd_in.
- MULHU: 0xFFFFFFFF × 0xFFFFFFFF → result=0xFFFFFFFE.
- MULH: 0x80000000 × 0x80000000 → result=0x40000000.
- DIV and REM: DIV −7 (0xFFFFFFF9) / 2 → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF; each has `busy` high for 33 cycles.
- Divide by zero: DIVU 5 / 0 → 0xFFFFFFFF with `done` at t+1; REMU 5 / 0 → 5 with `done` at t+1.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0, with `done` at t+1.
- Reset at CALC cycle 10 → `busy`=0 the next cycle, no `done`, result=0. A second `start` held high during `busy` in an earlier operation is ignored: exactly one `done` occurs.
